cabac_se_mvd_serializer: RTL and testbench



---
 rtl/cabac_se_mvd_serializer.sv | 202 ++++++++++++++++++++
 tb/tb_cabac_se_mvd_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_se_mvd_serializer.sv
// Emits HEVC mvd_coding()/mvp_lX_flag syntax-element pairs for one PU, L0 before L1, skipping uncoded steps.
// First pair registered one cycle after start_i; one pair per se_valid_o/se_ready_i handshake, outputs hold while stalled.
module cabac_se_mvd_serializer #(
  parameter  int MVD_W    = 11,
  parameter  int NUM_LIST = 2,
  localparam int VAL_W    = MVD_W - 1,
  localparam int PAIR_W   = VAL_W + 13
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [NUM_LIST-1:0]          list_en_i,
  input  logic [NUM_LIST*2*MVD_W-1:0]  mvd_i,
  input  logic [NUM_LIST-1:0]          mvp_idx_i,
  output logic                         se_valid_o,
  input  logic                         se_ready_i,
  output logic [PAIR_W-1:0]            se_pair_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int LIST_W = (NUM_LIST > 1) ? $clog2(NUM_LIST) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state, w_state_nx;
  logic [LIST_W-1:0]           r_list, w_list_nx, w_first, w_nxt_list;
  logic                        w_nxt_found;
  logic [3:0]                  r_step, w_step_nx, w_step_adv;
  logic                        r_se_valid, w_valid_nx;
  logic                        r_busy, w_busy_nx;
  logic                        r_done, w_done_nx;
  logic                        w_latch;
  logic                        w_hs;
  logic [PAIR_W-1:0]           r_se_pair, w_pair_nx;
  logic [NUM_LIST-1:0]         r_list_en, r_mvp;
  logic [NUM_LIST*2*MVD_W-1:0] r_mvd;
  logic [2*MVD_W-1:0]          w_in_mv, w_cur_mv, w_nl_mv;

  // Magnitude in VAL_W bits; the most negative code saturates to the largest magnitude.
  function automatic logic [VAL_W-1:0] f_abs(input logic [MVD_W-1:0] v);
    if (!v[MVD_W-1])
      f_abs = v[VAL_W-1:0];
    else if (v[VAL_W-1:0] == '0)
      f_abs = '1;
    else
      f_abs = -v[VAL_W-1:0];
  endfunction

  function automatic logic [8:0] f_mask(input logic [2*MVD_W-1:0] mv);
    logic [VAL_W-1:0] ax, ay;
    logic             gx0, gy0, gx1, gy1;
    ax  = f_abs(mv[2*MVD_W-1 -: MVD_W]);
    ay  = f_abs(mv[MVD_W-1:0]);
    gx0 = (ax != '0);
    gy0 = (ay != '0);
    gx1 = (ax > VAL_W'(1));
    gy1 = (ay > VAL_W'(1));
    f_mask = {1'b1, gy0, gy1, gx0, gx1, gy0, gx0, 2'b11};
  endfunction

  function automatic logic [PAIR_W-1:0] f_pair(input logic [2*MVD_W-1:0] mv,
                                               input logic mvp, input logic [3:0] step);
    logic [VAL_W-1:0] ax, ay, val;
    logic [8:0]       ctx;
    ax  = f_abs(mv[2*MVD_W-1 -: MVD_W]);
    ay  = f_abs(mv[MVD_W-1:0]);
    val = '0;
    ctx = '0;
    case (step)
      4'd0: begin val = VAL_W'(ax != '0);         ctx = 9'h016; end
      4'd1: begin val = VAL_W'(ay != '0);         ctx = 9'h016; end
      4'd2: begin val = VAL_W'(ax > VAL_W'(1));   ctx = 9'h017; end
      4'd3: begin val = VAL_W'(ay > VAL_W'(1));   ctx = 9'h017; end
      4'd4: begin val = ax - VAL_W'(2);           ctx = 9'h0be; end
      4'd5: begin val = VAL_W'(mv[2*MVD_W-1]);    ctx = 9'h0bb; end
      4'd6: begin val = ay - VAL_W'(2);           ctx = 9'h0be; end
      4'd7: begin val = VAL_W'(mv[MVD_W-1]);      ctx = 9'h0bb; end
      4'd8: begin val = VAL_W'(mvp);              ctx = 9'h0b0; end
      default: begin val = '0;                    ctx = '0;     end
    endcase
    f_pair = {val, 4'h1, ctx};
  endfunction

  // Lowest coded step above cur; step 8 is always coded so it bounds the search.
  function automatic logic [3:0] f_next(input logic [8:0] mask, input logic [3:0] cur);
    f_next = 4'd8;
    for (int i = 8; i >= 0; i--) begin
      if ((4'(i) > cur) && mask[i])
        f_next = 4'(i);
    end
  endfunction

  always_comb begin
    w_first     = '0;
    w_nxt_list  = r_list;
    w_nxt_found = 1'b0;
    for (int l = NUM_LIST-1; l >= 0; l--) begin
      if (list_en_i[l])
        w_first = LIST_W'(l);
      if ((LIST_W'(l) > r_list) && r_list_en[l]) begin
        w_nxt_list  = LIST_W'(l);
        w_nxt_found = 1'b1;
      end
    end
  end

  assign w_in_mv    = mvd_i[int'(w_first)*2*MVD_W +: 2*MVD_W];
  assign w_cur_mv   = r_mvd[int'(r_list)*2*MVD_W +: 2*MVD_W];
  assign w_nl_mv    = r_mvd[int'(w_nxt_list)*2*MVD_W +: 2*MVD_W];
  assign w_step_adv = f_next(f_mask(w_cur_mv), r_step);
  assign w_hs       = r_se_valid && se_ready_i;

  always_comb begin
    w_state_nx = r_state;
    w_list_nx  = r_list;
    w_step_nx  = r_step;
    w_valid_nx = r_se_valid;
    w_pair_nx  = r_se_pair;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_latch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_latch = 1'b1;
          if (list_en_i == '0) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = S_EMIT;
            w_list_nx  = w_first;
            w_step_nx  = 4'd0;
            w_valid_nx = 1'b1;
            w_busy_nx  = 1'b1;
            w_pair_nx  = f_pair(w_in_mv, mvp_idx_i[w_first], 4'd0);
          end
        end
      end
      S_EMIT: begin
        if (w_hs) begin
          if (r_step != 4'd8) begin
            w_step_nx = w_step_adv;
            w_pair_nx = f_pair(w_cur_mv, r_mvp[r_list], w_step_adv);
          end else if (w_nxt_found) begin
            w_list_nx = w_nxt_list;
            w_step_nx = 4'd0;
            w_pair_nx = f_pair(w_nl_mv, r_mvp[w_nxt_list], 4'd0);
          end else begin
            w_state_nx = S_DONE;
            w_list_nx  = '0;
            w_step_nx  = 4'd0;
            w_valid_nx = 1'b0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
            w_pair_nx  = '0;
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_list     <= '0;
      r_step     <= 4'd0;
      r_se_valid <= 1'b0;
      r_se_pair  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_list_en  <= '0;
      r_mvd      <= '0;
      r_mvp      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_list     <= w_list_nx;
      r_step     <= w_step_nx;
      r_se_valid <= w_valid_nx;
      r_se_pair  <= w_pair_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      if (w_latch) begin
        r_list_en <= list_en_i;
        r_mvd     <= mvd_i;
        r_mvp     <= mvp_idx_i;
      end
    end
  end

  assign se_valid_o = r_se_valid;
  assign se_pair_o  = r_se_pair;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_cabac_se_mvd_serializer.sv
// Scoreboard bench: an arithmetic reference model queues expected pairs per PU; a negedge monitor pops on each handshake.
module tb_cabac_se_mvd_serializer;

  localparam int MVD_W    = 11;
  localparam int NUM_LIST = 2;
  localparam int PAIR_W   = MVD_W - 1 + 13;

  logic                        clk;
  logic                        rst_n;
  logic                        start_i;
  logic [NUM_LIST-1:0]         list_en_i;
  logic [NUM_LIST*2*MVD_W-1:0] mvd_i;
  logic [NUM_LIST-1:0]         mvp_idx_i;
  logic                        se_valid_o;
  logic                        se_ready_i;
  logic [PAIR_W-1:0]           se_pair_o;
  logic                        busy_o;
  logic                        done_o;

  cabac_se_mvd_serializer #(.MVD_W(MVD_W), .NUM_LIST(NUM_LIST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .list_en_i  (list_en_i),
    .mvd_i      (mvd_i),
    .mvp_idx_i  (mvp_idx_i),
    .se_valid_o (se_valid_o),
    .se_ready_i (se_ready_i),
    .se_pair_o  (se_pair_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  typedef struct {
    logic [PAIR_W-1:0] pair;
    bit                last;
  } exp_t;

  exp_t              exp_q[$];
  int                n_cmp = 0;
  int                n_fail = 0;
  int                cyc = 0;
  int                rdy_mode = 1;
  bit                mon_en = 0;
  bit                exp_done = 0;
  bit                stall_prev = 0;
  logic [PAIR_W-1:0] stall_pair = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    se_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) se_ready_i = 1'($urandom_range(0, 1));
      else               se_ready_i = (rdy_mode == 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_se(input int v, input int ctx);
    exp_t       e;
    logic [9:0] vv;
    vv     = 10'(v);
    e.pair = {vv, 4'h1, 9'(ctx)};
    e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  // Reference: mvd_coding() element order built directly from signed component values.
  task automatic model(input logic [1:0] en, input logic [43:0] mvd, input logic [1:0] mvp,
                       output int n);
    logic [10:0] cx, cy;
    int          x, y, ax, ay;
    exp_t        e;
    n = 0;
    for (int l = 0; l < NUM_LIST; l++) begin
      if (en[l]) begin
        cx = mvd[l*22+11 +: 11];
        cy = mvd[l*22 +: 11];
        x  = $signed(cx);
        y  = $signed(cy);
        if (x == -1024) x = -1023;
        if (y == -1024) y = -1023;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        push_se(int'(ax != 0), 'h016); n++;
        push_se(int'(ay != 0), 'h016); n++;
        if (ax > 0) begin push_se(int'(ax > 1), 'h017); n++; end
        if (ay > 0) begin push_se(int'(ay > 1), 'h017); n++; end
        if (ax > 1) begin push_se(ax - 2, 'h0be); n++; end
        if (ax > 0) begin push_se(int'(x < 0), 'h0bb); n++; end
        if (ay > 1) begin push_se(ay - 2, 'h0be); n++; end
        if (ay > 0) begin push_se(int'(y < 0), 'h0bb); n++; end
        push_se(int'(mvp[l]), 'h0b0); n++;
      end
    end
    if (n > 0) begin
      e      = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!mon_en || !rst_n) begin
      exp_done   = 0;
      stall_prev = 0;
    end else begin
      if (exp_done) begin
        check("done_after_last", 32'(done_o), 32'd1);
        check("valid_after_last", 32'(se_valid_o), 32'd0);
        check("busy_after_last", 32'(busy_o), 32'd0);
        exp_done = 0;
      end
      if (stall_prev) begin
        check("stall_valid", 32'(se_valid_o), 32'd1);
        check("stall_pair", 32'(se_pair_o), 32'(stall_pair));
      end
      stall_prev = se_valid_o && !se_ready_i;
      stall_pair = se_pair_o;
      if (se_valid_o && se_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pair: got %h, expected no element (cycle %0d)", se_pair_o, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pair", 32'(se_pair_o), 32'(e.pair));
          if (e.last) exp_done = 1;
        end
      end
    end
  end

  function automatic logic [10:0] rand_comp();
    logic [10:0] r;
    case ($urandom_range(0, 5))
      0:       r = 11'h000;
      1:       r = ($urandom_range(0, 1) == 1) ? 11'h001 : 11'h7ff;
      2:       r = ($urandom_range(0, 1) == 1) ? 11'h002 : 11'h7fe;
      3:       r = 11'h400;
      4:       r = 11'h3ff;
      default: r = 11'($urandom);
    endcase
    return r;
  endfunction

  task automatic scramble_inputs();
    list_en_i = 2'($urandom_range(0, 3));
    mvd_i     = 44'({$urandom, $urandom});
    mvp_idx_i = 2'($urandom_range(0, 3));
  endtask

  task automatic run_pu(input logic [1:0] en, input logic [43:0] mvd, input logic [1:0] mvp,
                        input int rmode, input bit inject);
    int n;
    int t0;
    bit seen;
    rdy_mode = rmode;
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    list_en_i = en;
    mvd_i     = mvd;
    mvp_idx_i = mvp;
    model(en, mvd, mvp, n);
    t0 = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    scramble_inputs();
    @(negedge clk);
    if (en == 2'b00) begin
      check("empty_done", 32'(done_o), 32'd1);
      check("empty_valid", 32'(se_valid_o), 32'd0);
      check("empty_busy", 32'(busy_o), 32'd0);
      return;
    end
    check("first_valid", 32'(se_valid_o), 32'd1);
    check("first_busy", 32'(busy_o), 32'd1);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (inject) begin
        start_i = ($urandom_range(0, 3) == 0);
        scramble_inputs();
      end
      @(negedge clk);
      if (done_o) seen = 1;
    end
    start_i = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL pu_timeout: got no done_o within 400 cycles, expected done after %0d pairs", n);
    end else if (rmode == 1) begin
      check("full_rate_done_cycle", 32'(cyc), 32'(t0 + n + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start_i   = 1'b0;
    list_en_i = '0;
    mvd_i     = '0;
    mvp_idx_i = '0;
    #3;
    check("rst_valid", 32'(se_valid_o), 32'd0);
    check("rst_pair", 32'(se_pair_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;

    run_pu(2'b01, {11'h155, 11'h2aa, 11'd5, 11'd0}, 2'b01, 1, 0);
    run_pu(2'b01, {11'h001, 11'h001, 11'h7ff, 11'd1}, 2'b00, 1, 0);
    run_pu(2'b11, {11'h7fe, 11'd1023, 11'd0, 11'd0}, 2'b10, 1, 0);
    run_pu(2'b01, {11'd0, 11'd0, 11'h400, rand_comp()}, 2'b01, 1, 0);
    run_pu(2'b10, {rand_comp(), rand_comp(), rand_comp(), rand_comp()}, 2'b11, 1, 0);
    run_pu(2'b00, {rand_comp(), rand_comp(), rand_comp(), rand_comp()}, 2'b11, 1, 0);

    for (int k = 0; k < 40; k++)
      run_pu(2'($urandom_range(0, 3)), {rand_comp(), rand_comp(), rand_comp(), rand_comp()},
             2'($urandom_range(0, 3)), 2, 1);

    begin
      int n;
      rdy_mode = 0;
      @(posedge clk);
      #1;
      start_i   = 1'b1;
      list_en_i = 2'b11;
      mvd_i     = {11'h123, 11'h456, 11'h7f0, 11'h00f};
      mvp_idx_i = 2'b01;
      model(2'b11, mvd_i, 2'b01, n);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("busy_before_reset", 32'(busy_o), 32'd1);
      mon_en = 0;
      rst_n  = 1'b0;
      #1;
      check("midrst_valid", 32'(se_valid_o), 32'd0);
      check("midrst_pair", 32'(se_pair_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_done", 32'(done_o), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1;
    end

    run_pu(2'b11, {11'h7fe, 11'd1023, 11'd0, 11'd0}, 2'b10, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
